// File: rtl/crossing_wire_capture_pkg.sv
// Shared types and constants for the toggle-qualified crossing-wire receiver.
package crossing_wire_capture_pkg;

  typedef enum logic {
    StPrime = 1'b0,
    StRun   = 1'b1
  } state_e;

  localparam int unsigned DropCntW          = 8;
  localparam int unsigned DefaultSyncStages = 2;

endpackage

// File: rtl/crossing_toggle_sync.sv
// Multi-flop synchronizer for the source toggle line, cleared by synchronous reset.
module crossing_toggle_sync #(
  parameter int unsigned syncStages = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic STOGGLE,
  output logic syncOut
);

  logic [syncStages-1:0] chain_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[syncStages-2:0], STOGGLE};
    end
  end

  assign syncOut = chain_q[syncStages-1];

endmodule

// File: rtl/crossing_wire_capture.sv
// Destination-side receiver: syncs the toggle, detects events, holds one item for the consumer.
// Define CROSSING_CAPTURE_DROPCNT_EN to add the saturating DROPCNT output.
module crossing_wire_capture
  import crossing_wire_capture_pkg::*;
#(
  parameter int unsigned width      = 1,
  parameter int unsigned syncStages = DefaultSyncStages
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [width-1:0]    SVAL,
  input  logic                STOGGLE,
  output logic [width-1:0]    DGET,
  output logic                DRDY,
  input  logic                DEQ,
  output logic                OVERFLOW
`ifdef CROSSING_CAPTURE_DROPCNT_EN
  ,
  output logic [DropCntW-1:0] DROPCNT
`endif
);

  localparam int unsigned CntW = $clog2(syncStages + 1);

  logic             sync_out;
  logic             prev_q;
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [width-1:0] data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             ovf_q, ovf_d;
  logic             evt;
  logic             drop;

  crossing_toggle_sync #(
    .syncStages(syncStages)
  ) u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .STOGGLE(STOGGLE),
    .syncOut(sync_out)
  );

  // PRIME lets prev_q absorb whatever level the synchronizer settles to after reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt     = 1'b0;
    unique case (state_q)
      StPrime: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(syncStages)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        evt = sync_out ^ prev_q;
      end
    endcase
  end

  always_comb begin
    data_d = data_q;
    rdy_d  = rdy_q;
    ovf_d  = ovf_q;
    drop   = 1'b0;
    if (evt) begin
      if (rdy_q && !DEQ) begin
        drop  = 1'b1;
        ovf_d = 1'b1;
      end else begin
        data_d = SVAL;
        rdy_d  = 1'b1;
      end
    end else if (DEQ) begin
      rdy_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StPrime;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= sync_out;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign DGET     = data_q;
  assign DRDY     = rdy_q;
  assign OVERFLOW = ovf_q;

`ifdef CROSSING_CAPTURE_DROPCNT_EN
  logic [DropCntW-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != {DropCntW{1'b1}})) begin
      drop_d = drop_q + DropCntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign DROPCNT = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_crossing_wire_capture.sv
// Randomized self-checking bench for crossing_wire_capture against an event-schedule model.
module tb_crossing_wire_capture;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] SVAL;
  logic         STOGGLE;
  logic [W-1:0] DGET;
  logic         DRDY;
  logic         DEQ;
  logic         OVERFLOW;
`ifdef CROSSING_CAPTURE_DROPCNT_EN
  logic [7:0]   DROPCNT;
`endif

  always #5 CLK = ~CLK;

  crossing_wire_capture #(
    .width     (W),
    .syncStages(S)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SVAL    (SVAL),
    .STOGGLE (STOGGLE),
    .DGET    (DGET),
    .DRDY    (DRDY),
    .DEQ     (DEQ),
    .OVERFLOW(OVERFLOW)
`ifdef CROSSING_CAPTURE_DROPCNT_EN
    ,
    .DROPCNT (DROPCNT)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: each toggle is scheduled to land at a fixed edge; reset discards the schedule.
  typedef struct {
    int unsigned  due;
    logic [W-1:0] data;
  } ev_t;

  ev_t          pend[$];
  int unsigned  edge_n   = 0;
  int unsigned  last_tog = 0;
  logic [W-1:0] m_data   = '0;
  bit           m_rdy    = 1'b0;
  bit           m_ovf    = 1'b0;
  int           m_drops  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic step();
    bit  deq_s;
    bit  rst_s;
    ev_t e;
    deq_s = DEQ;
    rst_s = RST;
    @(posedge CLK);
    edge_n++;
    if (rst_s) begin
      pend.delete();
      m_data  = '0;
      m_rdy   = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else if (pend.size() > 0 && pend[0].due == edge_n) begin
      e = pend.pop_front();
      if (m_rdy && !deq_s) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end else begin
        m_data = e.data;
        m_rdy  = 1'b1;
      end
    end else if (deq_s) begin
      m_rdy = 1'b0;
    end
    #1;
    check_val("drdy", 32'(DRDY), 32'(m_rdy));
    check_val("dget", 32'(DGET), 32'(m_data));
    check_val("overflow", 32'(OVERFLOW), 32'(m_ovf));
`ifdef CROSSING_CAPTURE_DROPCNT_EN
    check_val("dropcnt", 32'(DROPCNT), 32'(m_drops));
`endif
  endtask

  // Called just after an edge: the change is first sampled on the next edge.
  task automatic toggle(input logic [W-1:0] v);
    ev_t e;
    SVAL    = v;
    STOGGLE = ~STOGGLE;
    e.due   = edge_n + 1 + S;
    e.data  = v;
    pend.push_back(e);
    last_tog = edge_n;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) step();
    RST = 1'b0;
    repeat (S + 2) step();
  endtask

  initial begin
    RST     = 1'b1;
    SVAL    = '0;
    STOGGLE = 1'b1;
    DEQ     = 1'b0;

    // Reset release with STOGGLE high must not fabricate an event.
    repeat (3) step();
    RST = 1'b0;
    repeat (20) step();
    check_val("prime_no_drdy", 32'(DRDY), 32'd0);
    check_val("prime_no_ovf", 32'(OVERFLOW), 32'd0);

    // Latency and capture.
    toggle(8'hA5);
    step();
    step();
    check_val("lat_edge2", 32'(DRDY), 32'd0);
    step();
    check_val("lat_edge3", 32'(DRDY), 32'd1);
    check_val("cap_a5", 32'(DGET), 32'hA5);
    DEQ = 1'b1;
    step();
    DEQ = 1'b0;
    check_val("deq_clears", 32'(DRDY), 32'd0);
    repeat (2) step();

    // Overflow while held.
    toggle(8'hA5);
    repeat (S + 2) step();
    toggle(8'h3C);
    repeat (S + 2) step();
    check_val("ovf_keep_a5", 32'(DGET), 32'hA5);
    check_val("ovf_set", 32'(OVERFLOW), 32'd1);
`ifdef CROSSING_CAPTURE_DROPCNT_EN
    check_val("dropcnt_1", 32'(DROPCNT), 32'd1);
`endif

    // Dequeue coinciding with the event replaces the item without overflow.
    do_reset(2);
    toggle(8'hA5);
    repeat (S + 2) step();
    toggle(8'h77);
    repeat (S) step();
    DEQ = 1'b1;
    step();
    DEQ = 1'b0;
    check_val("swap_drdy", 32'(DRDY), 32'd1);
    check_val("swap_dget", 32'(DGET), 32'h77);
    check_val("swap_no_ovf", 32'(OVERFLOW), 32'd0);
    step();

    // Saturating drops.
    for (int i = 0; i < 300; i++) begin
      toggle(W'($urandom));
      repeat (S + 2) step();
    end
    check_val("sat_ovf", 32'(OVERFLOW), 32'd1);
`ifdef CROSSING_CAPTURE_DROPCNT_EN
    check_val("sat_255", 32'(DROPCNT), 32'd255);
`endif
    RST = 1'b1;
    step();
    check_val("rst_drdy", 32'(DRDY), 32'd0);
    check_val("rst_ovf", 32'(OVERFLOW), 32'd0);
    check_val("rst_dget", 32'(DGET), 32'd0);
    RST = 1'b0;
    repeat (S + 2) step();

    // Reset right after a toggle: the pending item is lost.
    toggle(8'h5A);
    step();
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    repeat (10) step();
    check_val("rst_pending_lost", 32'(DRDY), 32'd0);

    // Randomized traffic respecting the minimum toggle spacing.
    for (int i = 0; i < 600; i++) begin
      DEQ = 1'($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        if ((edge_n - last_tog >= S + 2) && ($urandom_range(0, 2) == 0)) begin
          toggle(W'($urandom));
        end
        step();
      end
    end
    DEQ = 1'b0;
    repeat (S + 3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
